pipe_ifid: RTL and testbench

//  PC register plus IF/ID pipeline register, wrapped around pipe_if.
//  - Holds the fetch PC that drives pipe_if.pc and the icache address.
//  - Latches the next PC (npc) from pipe_if.
//  - Presents {inst, pc, pc8, valid} to the ID stage.
//  - Absorbs the 1-cycle synchronous icache latency, ID stalls (load-use) and redirect flushes.

---
 rtl/pipe_ifid_pkg.sv | 13 +
 rtl/pipe_ifid_hold_buf.sv | 52 +++++
 rtl/pipe_ifid.sv | 75 +++++++
 tb/tb_pipe_ifid.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ifid_pkg.sv
// Shared definitions for the IF/ID stage: default fetch address, NOP encoding and hold-buffer state codes.
package pipe_ifid_pkg;

    localparam logic [31:0] IFID_RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] IFID_NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFID_FILL = 2'd0,
        IFID_RUN  = 2'd1,
        IFID_HOLD = 2'd2
    } ifid_state_t;

endpackage

// File: rtl/pipe_ifid_hold_buf.sv
// Selects the ID-stage instruction: live icache data, a copy captured when a stall begins,
// or NOP when the IF/ID slot is empty.
module ifid_hold_buf
    import pipe_ifid_pkg::*;
#(
    parameter logic [31:0] NOP_INST = IFID_NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic        flush,
    input  logic        d_valid,
    input  logic [31:0] ram_outdata,
    output logic [31:0] d_inst
);

    ifid_state_t state;
    logic [31:0] hold_q;

    // While stalled the icache re-reads the held fetch pc, so the instruction already in ID
    // must be captured on the first stalled edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IFID_FILL;
            hold_q <= NOP_INST;
        end else if (flush) begin
            state  <= IFID_RUN;
            hold_q <= NOP_INST;
        end else if (!stall) begin
            state  <= IFID_RUN;
        end else begin
            unique case (state)
                IFID_RUN: begin
                    hold_q <= ram_outdata;
                    state  <= IFID_HOLD;
                end
                IFID_HOLD: state <= IFID_HOLD;
                IFID_FILL: state <= IFID_FILL;
                default:   state <= IFID_FILL;
            endcase
        end
    end

    always_comb begin
        d_inst = NOP_INST;
        if (d_valid) begin
            if (state == IFID_HOLD) d_inst = hold_q;
            else                    d_inst = ram_outdata;
        end
    end

endmodule

// File: rtl/pipe_ifid.sv
// Fetch PC register plus IF/ID pipeline register, absorbing icache latency, stalls and flushes.
// Optional performance counters are built when IFID_PERF_EN is defined.
module pipe_ifid
    import pipe_ifid_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFID_RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = IFID_NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] npc,
    input  logic [31:0] pc8_in,
    input  logic [31:0] ram_outdata,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc,
    output logic [31:0] d_inst,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid
`ifdef IFID_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    // Flush redirects fetch and empties the ID slot; d_pc/d_pc8 are don't-care while d_valid=0.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc      <= RESET_PC;
            d_pc    <= 32'h0;
            d_pc8   <= 32'h0;
            d_valid <= 1'b0;
        end else if (flush) begin
            pc      <= npc;
            d_valid <= 1'b0;
        end else if (!stall) begin
            pc      <= npc;
            d_pc    <= pc;
            d_pc8   <= pc8_in;
            d_valid <= 1'b1;
        end
    end

    ifid_hold_buf #(
        .NOP_INST (NOP_INST)
    ) u_hold_buf (
        .clk         (clk),
        .clrn        (clrn),
        .stall       (stall),
        .flush       (flush),
        .d_valid     (d_valid),
        .ram_outdata (ram_outdata),
        .d_inst      (d_inst)
    );

`ifdef IFID_PERF_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            perf_fetch <= 32'h0;
            perf_stall <= 32'h0;
            perf_flush <= 32'h0;
        end else if (flush) begin
            perf_flush <= perf_flush + 32'h1;
        end else if (stall) begin
            perf_stall <= perf_stall + 32'h1;
        end else begin
            perf_fetch <= perf_fetch + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ifid.sv
// Directed bench for pipe_ifid with a one-cycle synchronous icache model where inst(pc)=32'h1000_0000+pc/4.
module tb_pipe_ifid;

    logic        clk;
    logic        clrn;
    logic [31:0] npc;
    logic [31:0] pc8_in;
    logic [31:0] ram_outdata;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] d_inst;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        d_valid;
`ifdef IFID_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    logic        redirect;
    logic [31:0] target;
    int          n_compared;
    int          n_failed;

    localparam logic [31:0] NOP = 32'h0000_0000;

    pipe_ifid dut (
        .clk         (clk),
        .clrn        (clrn),
        .npc         (npc),
        .pc8_in      (pc8_in),
        .ram_outdata (ram_outdata),
        .stall       (stall),
        .flush       (flush),
        .pc          (pc),
        .d_inst      (d_inst),
        .d_pc        (d_pc),
        .d_pc8       (d_pc8),
        .d_valid     (d_valid)
`ifdef IFID_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pipe_if stand-in: sequential fetch unless a redirect target is presented
    assign npc    = redirect ? target : pc + 32'd4;
    assign pc8_in = pc + 32'd8;

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    always @(posedge clk) ram_outdata <= inst_of(pc);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp)
        else begin
            n_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_compared = 0;
        n_failed   = 0;
        clrn       = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        redirect   = 1'b0;
        target     = 32'h0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        check_output("rst_pc",      pc,             32'h0);
        check_output("rst_d_valid", 32'(d_valid),   32'h0);
        check_output("rst_d_inst",  d_inst,         NOP);
        check_output("rst_d_pc",    d_pc,           32'h0);
        check_output("rst_d_pc8",   d_pc8,          32'h0);

        // first fetch after reset
        step();
        check_output("s1_d_pc",     d_pc,           32'h0);
        check_output("s1_d_inst",   d_inst,         32'h1000_0000);
        check_output("s1_d_pc8",    d_pc8,          32'h8);
        check_output("s1_d_valid",  32'(d_valid),   32'h1);
        check_output("s1_pc",       pc,             32'h4);

        repeat (4) step();
        check_output("s2_pre_d_pc",   d_pc,   32'h10);
        check_output("s2_pre_d_inst", d_inst, 32'h1000_0004);

        // three stalled edges with d_pc=0x10
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("s2_hold_d_inst", d_inst, 32'h1000_0004);
            check_output("s2_hold_pc",     pc,     32'h14);
            check_output("s2_hold_d_pc",   d_pc,   32'h10);
        end
        stall = 1'b0;
        step();
        check_output("s2_rel_d_pc",   d_pc,   32'h14);
        check_output("s2_rel_d_inst", d_inst, 32'h1000_0005);
        check_output("s2_rel_pc",     pc,     32'h18);
        step();
        check_output("s2_next_d_inst", d_inst, 32'h1000_0006);

        // flush to 0x400 while d_pc=0x20
        repeat (2) step();
        check_output("s3_pre_d_pc", d_pc, 32'h20);
        flush    = 1'b1;
        redirect = 1'b1;
        target   = 32'h400;
        step();
        check_output("s3_fl_d_valid", 32'(d_valid), 32'h0);
        check_output("s3_fl_pc",      pc,           32'h400);
        check_output("s3_fl_d_inst",  d_inst,       NOP);
        flush    = 1'b0;
        redirect = 1'b0;
        step();
        check_output("s3_tgt_d_pc",    d_pc,         32'h400);
        check_output("s3_tgt_d_valid", 32'(d_valid), 32'h1);
        check_output("s3_tgt_d_inst",  d_inst,       32'h1000_0100);
        check_output("s3_tgt_d_pc8",   d_pc8,        32'h408);

        // enter HOLD, then stall and flush together
        stall = 1'b1;
        step();
        check_output("s4_hold_d_inst", d_inst, 32'h1000_0100);
        flush    = 1'b1;
        redirect = 1'b1;
        target   = 32'h800;
        step();
        check_output("s4_sf_d_valid", 32'(d_valid), 32'h0);
        check_output("s4_sf_pc",      pc,           32'h800);
        check_output("s4_sf_d_inst",  d_inst,       NOP);
        flush    = 1'b0;
        redirect = 1'b0;
        step();
        check_output("s4_st_d_inst", d_inst, NOP);
        check_output("s4_st_pc",     pc,     32'h800);
        stall = 1'b0;
        step();
        check_output("s4_rel_d_pc",    d_pc,         32'h800);
        check_output("s4_rel_d_valid", 32'(d_valid), 32'h1);
        check_output("s4_rel_d_inst",  d_inst,       32'h1000_0200);

        // async reset while in HOLD
        stall = 1'b1;
        repeat (2) step();
        check_output("s5_hold_d_inst", d_inst, 32'h1000_0200);
        check_output("s5_hold_pc",     pc,     32'h804);
        #2;
        clrn = 1'b0;
        #1;
        check_output("s5_rst_pc",      pc,           32'h0);
        check_output("s5_rst_d_valid", 32'(d_valid), 32'h0);
        check_output("s5_rst_d_inst",  d_inst,       NOP);
        check_output("s5_rst_d_pc",    d_pc,         32'h0);
        stall = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        step();
        check_output("s5_res_d_pc",   d_pc,   32'h0);
        check_output("s5_res_d_inst", d_inst, 32'h1000_0000);
        check_output("s5_res_d_pc8",  d_pc8,  32'h8);

        // 10 run edges in total since reset, then 3 stalls and 1 flush
        repeat (9) step();
        check_output("s6_run_d_pc", d_pc, 32'h24);
        stall = 1'b1;
        repeat (3) step();
        check_output("s6_st_d_pc",   d_pc,   32'h24);
        check_output("s6_st_d_inst", d_inst, 32'h1000_0009);
        stall    = 1'b0;
        flush    = 1'b1;
        redirect = 1'b1;
        target   = 32'h100;
        step();
        check_output("s6_fl_pc",      pc,           32'h100);
        check_output("s6_fl_d_valid", 32'(d_valid), 32'h0);
        flush    = 1'b0;
        redirect = 1'b0;
`ifdef IFID_PERF_EN
        check_output("perf_fetch", perf_fetch, 32'd10);
        check_output("perf_stall", perf_stall, 32'd3);
        check_output("perf_flush", perf_flush, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
